vga_timing_gen: RTL and testbench

Parametrised, self-counting VGA timing generator; successor to the purely combinational sync decoder, which needs externally supplied counters. It owns the pixel-rate divider and the horizontal/vertical counters. It decodes sync, blanking and coordinates with programmable porch widths and sync polarity, and emits line/frame strobes for the game renderer. It sits between the board clock and the pixel-generation/colour logic that drives the VGA connector.

---
 rtl/vga_timing_gen.sv | 127 ++++++++++++
 tb/tb_vga_timing_gen.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: self-counting VGA timing generator with optional pixel divider.
// Build macro VGA_TIMING_CLKDIV_EN enables the internal CLK_DIV divider.
//
// Ports:
//   clk, reset             system clock, synchronous active-high reset
//   pix_en_in              external pixel enable (used when divider is absent)
//   pix_tick               pixel-rate enable; counters advance when high
//   h_count, v_count       horizontal / vertical counters
//   x_loc, y_loc           pixel coordinates (mirror the counters)
//   video_on               high inside the visible area
//   h_sync, v_sync         sync outputs, active level set by HS_POL / VS_POL
//   line_start             strobe in the last clk of pixel 0 of each line
//   frame_start            strobe in the last clk of pixel (0,0)
//   frame_count            completed frames, modulo 256
module vga_timing_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit HS_POL    = 1'b0,
  parameter bit VS_POL    = 1'b0,
  parameter int CNT_W     = 10,
  parameter int CLK_DIV   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pix_en_in,
  output logic             pix_tick,
  output logic [CNT_W-1:0] h_count,
  output logic [CNT_W-1:0] v_count,
  output logic [CNT_W-1:0] x_loc,
  output logic [CNT_W-1:0] y_loc,
  output logic             video_on,
  output logic             h_sync,
  output logic             v_sync,
  output logic             line_start,
  output logic             frame_start,
  output logic [7:0]       frame_count
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CNT_W-1:0] LP_H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] LP_V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] LP_H_DISP = CNT_W'(H_DISPLAY);
  localparam logic [CNT_W-1:0] LP_V_DISP = CNT_W'(V_DISPLAY);
  localparam logic [CNT_W-1:0] LP_HS_BEG = CNT_W'(H_DISPLAY + H_FRONT);
  localparam logic [CNT_W-1:0] LP_HS_END = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] LP_VS_BEG = CNT_W'(V_DISPLAY + V_FRONT);
  localparam logic [CNT_W-1:0] LP_VS_END = CNT_W'(V_DISPLAY + V_FRONT + V_SYNC);

  logic [CNT_W-1:0] r_h;
  logic [CNT_W-1:0] r_v;
  logic [7:0]       r_frame;
  logic             w_tick;
  logic             w_h_last;
  logic             w_v_last;
  logic             w_h_zero;
  logic             w_v_zero;

`ifdef VGA_TIMING_CLKDIV_EN
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] LP_DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] r_div;
  logic             w_unused_pix_en;

  assign w_unused_pix_en = pix_en_in;
  assign w_tick = (r_div == LP_DIV_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div <= '0;
    end else if (w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end
`else
  assign w_tick = pix_en_in;
`endif

  assign w_h_last = (r_h == LP_H_LAST);
  assign w_v_last = (r_v == LP_V_LAST);
  assign w_h_zero = (r_h == '0);
  assign w_v_zero = (r_v == '0);

  // v and frame counters only move on the h wrap edge
  always_ff @(posedge clk) begin
    if (reset) begin
      r_h     <= '0;
      r_v     <= '0;
      r_frame <= '0;
    end else if (w_tick) begin
      if (w_h_last) begin
        r_h <= '0;
        if (w_v_last) begin
          r_v     <= '0;
          r_frame <= r_frame + 8'd1;
        end else begin
          r_v <= r_v + CNT_W'(1);
        end
      end else begin
        r_h <= r_h + CNT_W'(1);
      end
    end
  end

  assign pix_tick    = w_tick;
  assign h_count     = r_h;
  assign v_count     = r_v;
  assign x_loc       = r_h;
  assign y_loc       = r_v;
  assign frame_count = r_frame;
  assign video_on    = (r_h < LP_H_DISP) && (r_v < LP_V_DISP);
  assign h_sync      = ((r_h >= LP_HS_BEG) && (r_h < LP_HS_END)) ? HS_POL : ~HS_POL;
  assign v_sync      = ((r_v >= LP_VS_BEG) && (r_v < LP_VS_END)) ? VS_POL : ~VS_POL;
  assign line_start  = w_tick & w_h_zero;
  assign frame_start = w_tick & w_h_zero & w_v_zero;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: random enable/reset stimulus on a default-sized and a
// tiny positive-polarity generator, checked against a tick-count model.
module tb_vga_timing_gen;

  localparam int D_DIV = 4;
  localparam int S_DIV = 1;
  localparam int S_HD = 8, S_HF = 1, S_HS = 2, S_HB = 1;
  localparam int S_VD = 4, S_VF = 1, S_VS = 1, S_VB = 1;

  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
    logic       von;
    logic       hs;
    logic       vs;
    logic [7:0] fc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pix_en_in = 1'b0;

  always #5 clk = ~clk;

  logic       d_pt, d_von, d_hs, d_vs, d_ls, d_fs;
  logic [9:0] d_h, d_v, d_x, d_y;
  logic [7:0] d_fc;
  logic       s_pt, s_von, s_hs, s_vs, s_ls, s_fs;
  logic [9:0] s_h, s_v, s_x, s_y;
  logic [7:0] s_fc;

  vga_timing_gen #(
    .CLK_DIV(D_DIV)
  ) u_dut_def (
    .clk(clk), .reset(reset), .pix_en_in(pix_en_in),
    .pix_tick(d_pt), .h_count(d_h), .v_count(d_v),
    .x_loc(d_x), .y_loc(d_y), .video_on(d_von),
    .h_sync(d_hs), .v_sync(d_vs), .line_start(d_ls),
    .frame_start(d_fs), .frame_count(d_fc)
  );

  vga_timing_gen #(
    .H_DISPLAY(S_HD), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
    .V_DISPLAY(S_VD), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB),
    .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(10), .CLK_DIV(S_DIV)
  ) u_dut_small (
    .clk(clk), .reset(reset), .pix_en_in(pix_en_in),
    .pix_tick(s_pt), .h_count(s_h), .v_count(s_v),
    .x_loc(s_x), .y_loc(s_y), .video_on(s_von),
    .h_sync(s_hs), .v_sync(s_vs), .line_start(s_ls),
    .frame_start(s_fs), .frame_count(s_fc)
  );

  int n_chk = 0;
  int n_fail = 0;

  longint d_n, s_n;
  int     d_c, s_c;
  logic   d_tk, s_tk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Position follows purely from the number of ticks since reset.
  function automatic exp_t model(longint n, int hd, int hf, int hs, int hb,
                                 int vd, int vf, int vs, int vb,
                                 bit hp, bit vp);
    exp_t   e;
    longint ht, vt, h, v;
    ht = hd + hf + hs + hb;
    vt = vd + vf + vs + vb;
    h = n % ht;
    v = (n / ht) % vt;
    e.h   = 10'(h);
    e.v   = 10'(v);
    e.fc  = 8'((n / (ht * vt)) % 256);
    e.von = (h < hd) && (v < vd);
    e.hs  = (h >= hd + hf && h < hd + hf + hs) ? hp : ~hp;
    e.vs  = (v >= vd + vf && v < vd + vf + vs) ? vp : ~vp;
    return e;
  endfunction

  function automatic logic exp_tick(int c, int div, logic en);
`ifdef VGA_TIMING_CLKDIV_EN
    exp_tick = ((c % div) == div - 1);
`else
    exp_tick = en;
`endif
  endfunction

  task automatic check_inst(input string nm, input exp_t e, input logic tk,
                            input logic pt, input logic [9:0] h,
                            input logic [9:0] v, input logic [9:0] x,
                            input logic [9:0] y, input logic von,
                            input logic hs, input logic vs, input logic ls,
                            input logic fs, input logic [7:0] fc);
    chk({nm, ".pix_tick"}, 32'(pt), 32'(tk));
    chk({nm, ".h_count"}, 32'(h), 32'(e.h));
    chk({nm, ".v_count"}, 32'(v), 32'(e.v));
    chk({nm, ".x_loc"}, 32'(x), 32'(e.h));
    chk({nm, ".y_loc"}, 32'(y), 32'(e.v));
    chk({nm, ".video_on"}, 32'(von), 32'(e.von));
    chk({nm, ".h_sync"}, 32'(hs), 32'(e.hs));
    chk({nm, ".v_sync"}, 32'(vs), 32'(e.vs));
    chk({nm, ".line_start"}, 32'(ls), 32'(tk && e.h == 0));
    chk({nm, ".frame_start"}, 32'(fs), 32'(tk && e.h == 0 && e.v == 0));
    chk({nm, ".frame_count"}, 32'(fc), 32'(e.fc));
  endtask

  // Called just after a posedge: drive, check, advance one clock, update model.
  task automatic step(input logic rst, input logic en);
    exp_t de, se;
    reset = rst;
    pix_en_in = en;
    d_tk = exp_tick(d_c, D_DIV, en);
    s_tk = exp_tick(s_c, S_DIV, en);
    #1;
    de = model(d_n, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
    se = model(s_n, S_HD, S_HF, S_HS, S_HB, S_VD, S_VF, S_VS, S_VB,
               1'b1, 1'b1);
    check_inst("def", de, d_tk, d_pt, d_h, d_v, d_x, d_y, d_von, d_hs,
               d_vs, d_ls, d_fs, d_fc);
    check_inst("small", se, s_tk, s_pt, s_h, s_v, s_x, s_y, s_von, s_hs,
               s_vs, s_ls, s_fs, s_fc);
    @(posedge clk);
    #1;
    if (rst) begin
      d_n = 0; d_c = 0;
      s_n = 0; s_c = 0;
    end else begin
      if (d_tk) d_n++;
      if (s_tk) s_n++;
      d_c = (d_c + 1) % D_DIV;
      s_c = (s_c + 1) % S_DIV;
    end
  endtask

  initial begin
    d_n = 0; s_n = 0; d_c = 0; s_c = 0;
    d_tk = 1'b0; s_tk = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) step(1'b1, 1'($urandom_range(0, 1)));
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    // Phase with occasional mid-frame resets.
    for (int i = 0; i < 4000; i++)
      step(($urandom_range(0, 999) == 0), ($urandom_range(0, 3) != 0));
    // Long run without reset so the small frame counter rolls over.
    for (int i = 0; i < 26000; i++)
      step(1'b0, ($urandom_range(0, 7) != 0));
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
